// File: rtl/mult_block_host.sv
// mult_block_host -- host-side controller for the multiplier block client port.
//
// Drives a burst of operand pairs (two arithmetic sequences) with EN_mult held
// continuously until the multiplier reports its result memory full (RDY_mult
// low), then requests a block read and accumulates the streamed results.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle pulse, accepted only while idle
//   op0_base/op0_step operand-0 sequence (first value, per-cycle increment)
//   op1_base/op1_step operand-1 sequence
//   EN_mult           burst enable to the multiplier
//   mult_input0/1     operand pair presented while EN_mult is high
//   RDY_mult          multiplier ready; low = result memory full
//   EN_blockRead      block-read request, held until the first valid word
//   VALID_memVal      result word valid
//   memVal_data       result word
//   busy              high whenever not idle
//   done              one-cycle completion pulse
//   word_count        words received in the last run
//   data_sum          sum of the words received in the last run
//   error             last run timed out (feed or read request)
//   fed_count         operand pairs issued in the last run (saturates at 255)
//   mismatch_count    (MULT_BLOCK_HOST_CHECK_EN only) result words that differ
//                     from the expected product, saturating at 255
//
// Build option: define MULT_BLOCK_HOST_CHECK_EN to add the result checker.

module mult_block_host #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 64,
  parameter int TIMEOUT   = 255,
  parameter int PIPE_SKEW = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [WIDTH-1:0]              op0_base,
  input  logic [WIDTH-1:0]              op0_step,
  input  logic [WIDTH-1:0]              op1_base,
  input  logic [WIDTH-1:0]              op1_step,
  output logic                          EN_mult,
  output logic [WIDTH-1:0]              mult_input0,
  output logic [WIDTH-1:0]              mult_input1,
  input  logic                          RDY_mult,
  output logic                          EN_blockRead,
  input  logic                          VALID_memVal,
  input  logic [WIDTH-1:0]              memVal_data,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(DEPTH):0]        word_count,
  output logic [WIDTH+$clog2(DEPTH)-1:0] data_sum,
  output logic                          error,
  output logic [7:0]                    fed_count
`ifdef MULT_BLOCK_HOST_CHECK_EN
  ,
  output logic [7:0]                    mismatch_count
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = WIDTH + $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FEED, S_RELEASE, S_REQ, S_DRAIN, S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] step0, step1;
  logic [TW-1:0]    timer;
  logic             last_feed;   // RDY_mult seen low; one more enabled cycle due

  // A word is accepted in REQ (the first one) and in DRAIN; DRAIN is left as
  // soon as DEPTH words are in, so later words are never accepted.
  logic take_word;
  assign take_word = VALID_memVal && (state == S_REQ || state == S_DRAIN);

  logic at_depth;
  assign at_depth = (word_count == CW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      EN_mult      <= 1'b0;
      EN_blockRead <= 1'b0;
      mult_input0  <= '0;
      mult_input1  <= '0;
      step0        <= '0;
      step1        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      word_count   <= '0;
      data_sum     <= '0;
      error        <= 1'b0;
      fed_count    <= '0;
      timer        <= '0;
      last_feed    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            step0       <= op0_step;
            step1       <= op1_step;
            mult_input0 <= op0_base;
            mult_input1 <= op1_base;
            word_count  <= '0;
            data_sum    <= '0;
            error       <= 1'b0;
            fed_count   <= '0;
            timer       <= '0;
            last_feed   <= 1'b0;
            EN_mult     <= 1'b1;
            busy        <= 1'b1;
            state       <= S_FEED;
          end
        end

        // EN_mult must stay high without gaps: a dropped cycle resets the
        // multiplier's write address.
        S_FEED: begin
          mult_input0 <= mult_input0 + step0;
          mult_input1 <= mult_input1 + step1;
          if (fed_count != 8'hFF) fed_count <= fed_count + 8'd1;
          timer <= timer + 1'b1;
          if (last_feed) begin
            EN_mult   <= 1'b0;
            last_feed <= 1'b0;
            state     <= S_RELEASE;
          end else if (!RDY_mult) begin
            // Full takes priority over a coincident timeout.
            last_feed <= 1'b1;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            EN_mult <= 1'b0;
            error   <= 1'b1;
            done    <= 1'b1;
            state   <= S_DONE;
          end
        end

        S_RELEASE: begin
          EN_blockRead <= 1'b1;
          timer        <= '0;
          state        <= S_REQ;
        end

        S_REQ: begin
          if (VALID_memVal) begin
            EN_blockRead <= 1'b0;
            word_count   <= word_count + 1'b1;
            data_sum     <= data_sum + SW'(memVal_data);
            if (at_depth) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_DRAIN;
            end
          end else if (timer == TW'(TIMEOUT - 1)) begin
            EN_blockRead <= 1'b0;
            error        <= 1'b1;
            done         <= 1'b1;
            state        <= S_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_DRAIN: begin
          if (VALID_memVal) begin
            word_count <= word_count + 1'b1;
            data_sum   <= data_sum + SW'(memVal_data);
            if (at_depth) begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MULT_BLOCK_HOST_CHECK_EN
  // Shadow generator: replays both operand sequences from base, advancing
  // once per received word at or beyond PIPE_SKEW, so word k is compared
  // with the product of pair k-PIPE_SKEW.
  logic [WIDTH-1:0]   sh0, sh1, sh_step0, sh_step1;
  logic [2*WIDTH-1:0] sh_prod;
  logic               chk_word;

  assign sh_prod  = sh0 * sh1;
  assign chk_word = take_word && (int'(word_count) >= PIPE_SKEW);

  always_ff @(posedge clk) begin
    if (rst) begin
      sh0            <= '0;
      sh1            <= '0;
      sh_step0       <= '0;
      sh_step1       <= '0;
      mismatch_count <= '0;
    end else if (state == S_IDLE && start) begin
      sh0            <= op0_base;
      sh1            <= op1_base;
      sh_step0       <= op0_step;
      sh_step1       <= op1_step;
      mismatch_count <= '0;
    end else if (chk_word) begin
      sh0 <= sh0 + sh_step0;
      sh1 <= sh1 + sh_step1;
      if (memVal_data != sh_prod[WIDTH-1:0] && mismatch_count != 8'hFF)
        mismatch_count <= mismatch_count + 8'd1;
    end
  end
`else
  logic unused_take;
  assign unused_take = take_word;
`endif

endmodule
